// File: rtl/rv32v_mem_lane_sequencer.sv
// Two-lane vector memory sequencer: serialises active load/store lanes onto one scalar
// data-memory port, gathers load data, then writes both lanes back together.
module rv32v_mem_lane_sequencer #(
  parameter int OFFSET_W = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ex_valid,
  input  logic                ex_load,
  input  logic                ex_store,
  input  logic                ex_config,
  input  logic                ex_wen0,
  input  logic                ex_wen1,
  input  logic [31:0]         ex_alu0,
  input  logic [31:0]         ex_alu1,
  input  logic [31:0]         ex_sdata0,
  input  logic [31:0]         ex_sdata1,
  input  logic [OFFSET_W-1:0] ex_woff0,
  input  logic [OFFSET_W-1:0] ex_woff1,
  input  logic [31:0]         ex_vl,
  input  logic [31:0]         ex_vtype,
  output logic                ex_stall,
  output logic                dmem_ren,
  output logic                dmem_wen,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_busy,
  input  logic [31:0]         dmem_rdata,
  output logic                wb_en0,
  output logic                wb_en1,
  output logic [31:0]         wb_data0,
  output logic [31:0]         wb_data1,
  output logic [OFFSET_W-1:0] wb_off0,
  output logic [OFFSET_W-1:0] wb_off1,
  output logic                cfg_wen,
  output logic [31:0]         cfg_vl,
  output logic [31:0]         cfg_vtype,
  output logic                err
);

  typedef logic [OFFSET_W-1:0] offset_t;
  typedef enum logic [2:0] {S_IDLE, S_REQ0, S_REQ1, S_WB, S_CFG} state_t;

  state_t        state_q, state_d;
  logic          err_q, err_d;
  logic          load_q, load_d, store_q, store_d;
  logic          wen0_q, wen0_d, wen1_q, wen1_d;
  logic [31:0]   alu0_q, alu0_d, alu1_q, alu1_d;
  logic [31:0]   sd0_q, sd0_d, sd1_q, sd1_d;
  logic [31:0]   rd0_q, rd0_d, rd1_q, rd1_d;
  logic [31:0]   vl_q, vl_d, vtype_q, vtype_d;
  offset_t       off0_q, off0_d, off1_q, off1_d;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    load_d  = load_q;  store_d = store_q;
    wen0_d  = wen0_q;  wen1_d  = wen1_q;
    alu0_d  = alu0_q;  alu1_d  = alu1_q;
    sd0_d   = sd0_q;   sd1_d   = sd1_q;
    rd0_d   = rd0_q;   rd1_d   = rd1_q;
    vl_d    = vl_q;    vtype_d = vtype_q;
    off0_d  = off0_q;  off1_d  = off1_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (ex_load && ex_store) begin
            err_d = 1'b1;
          end else begin
            load_d  = ex_load;   store_d = ex_store;
            wen0_d  = ex_wen0;   wen1_d  = ex_wen1;
            alu0_d  = ex_alu0;   alu1_d  = ex_alu1;
            sd0_d   = ex_sdata0; sd1_d   = ex_sdata1;
            vl_d    = ex_vl;     vtype_d = ex_vtype;
            off0_d  = ex_woff0;  off1_d  = ex_woff1;
            if (ex_config)                            state_d = S_CFG;
            else if ((ex_load || ex_store) && ex_wen0) state_d = S_REQ0;
            else if ((ex_load || ex_store) && ex_wen1) state_d = S_REQ1;
            else                                       state_d = S_WB;
          end
        end
      end
      S_REQ0: begin
        if (!dmem_busy) begin
          rd0_d   = dmem_rdata;
          state_d = wen1_q ? S_REQ1 : S_WB;
        end
      end
      S_REQ1: begin
        if (!dmem_busy) begin
          rd1_d   = dmem_rdata;
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_CFG:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Bundle payload is not reset; every output that exposes it is qualified by state.
  always_ff @(posedge CLK) begin
    load_q <= load_d;  store_q <= store_d;
    wen0_q <= wen0_d;  wen1_q  <= wen1_d;
    alu0_q <= alu0_d;  alu1_q  <= alu1_d;
    sd0_q  <= sd0_d;   sd1_q   <= sd1_d;
    rd0_q  <= rd0_d;   rd1_q   <= rd1_d;
    vl_q   <= vl_d;    vtype_q <= vtype_d;
    off0_q <= off0_d;  off1_q  <= off1_d;
  end

  logic in_req0, in_req1, in_wb, in_cfg;

  always_comb begin
    in_req0    = (state_q == S_REQ0);
    in_req1    = (state_q == S_REQ1);
    in_wb      = (state_q == S_WB);
    in_cfg     = (state_q == S_CFG);
    ex_stall   = (state_q != S_IDLE);
    dmem_ren   = (in_req0 || in_req1) && load_q;
    dmem_wen   = (in_req0 || in_req1) && store_q;
    dmem_addr  = in_req0 ? alu0_q : (in_req1 ? alu1_q : 32'd0);
    dmem_wdata = in_req0 ? sd0_q  : (in_req1 ? sd1_q  : 32'd0);
    wb_en0     = in_wb && wen0_q && !store_q;
    wb_en1     = in_wb && wen1_q && !store_q;
    wb_data0   = in_wb ? (load_q ? rd0_q : alu0_q) : 32'd0;
    wb_data1   = in_wb ? (load_q ? rd1_q : alu1_q) : 32'd0;
    wb_off0    = in_wb ? off0_q : '0;
    wb_off1    = in_wb ? off1_q : '0;
    cfg_wen    = in_cfg;
    cfg_vl     = in_cfg ? vl_q : 32'd0;
    cfg_vtype  = in_cfg ? vtype_q : 32'd0;
    err        = err_q;
  end

endmodule
